// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice scheduler for the tone datapath.
// Watches the key levels and services exactly one key event per cycle
// into a shadow voice table. Releases win over presses, and the lowest
// key index wins within each kind.
// The shadow table is copied to the voice outputs only on sample_tick.
// The copy includes any event serviced in that same cycle.
// steal_evt is registered. It is high in the cycle after the edge that
// serviced the stealing press, the same cycle the shadow change becomes
// visible.
module voice_allocator #(
    parameter int NUM_KEYS   = 10,
    parameter int NUM_VOICES = 4,
    parameter int INC_W      = 18
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    input  logic [NUM_KEYS-1:0]         key_in,
    input  logic                        sample_tick,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic [4*NUM_VOICES-1:0]     voice_key,
    output logic [INC_W*NUM_VOICES-1:0] voice_inc,
    output logic [NUM_VOICES-1:0]       voice_start,
    output logic                        steal_evt
);

    localparam int              AGE_W    = $clog2(NUM_VOICES);
    localparam int              VID_W    = $clog2(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);
    localparam logic [3:0]      IDLE_KEY = 4'hF;

    // Phase increment for a key index; unknown or idle keys give 0.
    function automatic logic [INC_W-1:0] inc_of(input logic [3:0] k);
        logic [31:0] v;
        case (k)
            4'd0:    v = 32'd91446;
            4'd1:    v = 32'd102641;
            4'd2:    v = 32'd115214;
            4'd3:    v = 32'd122064;
            4'd4:    v = 32'd137013;
            4'd5:    v = 32'd153791;
            4'd6:    v = 32'd172624;
            4'd7:    v = 32'd182891;
            4'd8:    v = 32'd205288;
            4'd9:    v = 32'd230425;
            default: v = 32'd0;
        endcase
        return INC_W'(v);
    endfunction

    // Key ownership and steal blocking.
    logic [NUM_KEYS-1:0]   ack;
    logic [NUM_KEYS-1:0]   blocked;
    // Shadow voice table.
    logic [NUM_VOICES-1:0] sh_active;
    logic [3:0]            sh_key [NUM_VOICES];
    logic [AGE_W-1:0]      sh_age [NUM_VOICES];
    logic [NUM_VOICES-1:0] pend;

    // Next-state values.
    logic [NUM_KEYS-1:0]   ack_n;
    logic [NUM_KEYS-1:0]   blk_n;
    logic [NUM_VOICES-1:0] act_n;
    logic [3:0]            key_n [NUM_VOICES];
    logic [AGE_W-1:0]      age_n [NUM_VOICES];
    logic [NUM_VOICES-1:0] pend_n;
    logic                  steal_n;

    // Scratch values for event selection.
    logic [NUM_KEYS-1:0]   rel_vec;
    logic [NUM_KEYS-1:0]   prs_vec;
    logic                  rel_found;
    logic                  prs_found;
    logic                  free_found;
    logic [3:0]            rel_idx;
    logic [3:0]            prs_idx;
    logic [VID_W-1:0]      free_idx;
    logic [VID_W-1:0]      old_idx;
    logic [AGE_W-1:0]      old_age;
    logic [VID_W-1:0]      tgt;

    // Select this cycle's single event and compute the updated shadow table.
    always_comb begin
        ack_n   = ack;
        blk_n   = blocked & key_in;   // a stolen key unblocks once it is let go
        act_n   = sh_active;
        pend_n  = pend;
        steal_n = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            key_n[v] = sh_key[v];
            age_n[v] = sh_age[v];
        end

        // A blocked key is still held but is not a new request.
        rel_vec = ~key_in & ack;
        prs_vec = key_in & ~ack & ~blocked;

        // Scan downward so that the lowest index is selected.
        rel_found = 1'b0;
        rel_idx   = 4'd0;
        prs_found = 1'b0;
        prs_idx   = 4'd0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (rel_vec[k]) begin
                rel_found = 1'b1;
                rel_idx   = 4'(k);
            end
            if (prs_vec[k]) begin
                prs_found = 1'b1;
                prs_idx   = 4'(k);
            end
        end

        // Find the lowest idle voice and the oldest voice.
        // Ties on age go to the lowest index.
        free_found = 1'b0;
        free_idx   = '0;
        old_idx    = '0;
        old_age    = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!sh_active[v]) begin
                free_found = 1'b1;
                free_idx   = VID_W'(v);
            end
            if (sh_age[v] >= old_age) begin
                old_age = sh_age[v];
                old_idx = VID_W'(v);
            end
        end
        tgt = free_found ? free_idx : old_idx;

        if (rel_found) begin
            ack_n[rel_idx] = 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (sh_active[v] && sh_key[v] == rel_idx) begin
                    act_n[v]  = 1'b0;
                    key_n[v]  = IDLE_KEY;
                    pend_n[v] = 1'b0;   // an uncommitted note is never heard
                end
            end
        end else if (prs_found) begin
            if (!free_found) begin
                steal_n = 1'b1;
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (sh_key[tgt] == 4'(k)) begin
                        ack_n[k] = 1'b0;
                        blk_n[k] = 1'b1;
                    end
                end
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (VID_W'(v) == tgt) begin
                    age_n[v] = '0;
                end else if (sh_active[v]) begin
                    age_n[v] = (sh_age[v] == AGE_MAX) ? AGE_MAX : sh_age[v] + 1'b1;
                end
            end
            act_n[tgt]     = 1'b1;
            key_n[tgt]     = prs_idx;
            pend_n[tgt]    = 1'b1;
            ack_n[prs_idx] = 1'b1;
        end
    end

    // Register the shadow table and commit it to the outputs on sample ticks.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            ack          <= '0;
            blocked      <= '0;
            sh_active    <= '0;
            pend         <= '0;
            steal_evt    <= 1'b0;
            voice_active <= '0;
            voice_key    <= {NUM_VOICES{IDLE_KEY}};
            voice_inc    <= '0;
            voice_start  <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                sh_key[v] <= IDLE_KEY;
                sh_age[v] <= '0;
            end
        end else begin
            ack       <= ack_n;
            blocked   <= blk_n;
            sh_active <= act_n;
            steal_evt <= steal_n;
            for (int v = 0; v < NUM_VOICES; v++) begin
                sh_key[v] <= key_n[v];
                sh_age[v] <= age_n[v];
            end
            if (sample_tick) begin
                voice_active <= act_n;
                voice_start  <= pend_n;
                pend         <= '0;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    voice_key[4*v +: 4]         <= key_n[v];
                    voice_inc[INC_W*v +: INC_W] <= act_n[v] ? inc_of(key_n[v]) : '0;
                end
            end else begin
                voice_start <= '0;
                pend        <= pend_n;
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator.
// A behavioural voice-table model predicts every output word after each
// clock edge. Directed scenarios are followed by a randomized key/tick
// phase with occasional asynchronous resets.
module tb_voice_allocator;

    localparam int NK = 10;
    localparam int NV = 4;
    localparam int IW = 18;
    localparam int W  = 1 + NV + IW*NV + 4*NV + NV;

    logic              CLOCK_50;
    logic              resetn;
    logic [NK-1:0]     key_in;
    logic              sample_tick;
    logic [NV-1:0]     voice_active;
    logic [4*NV-1:0]   voice_key;
    logic [IW*NV-1:0]  voice_inc;
    logic [NV-1:0]     voice_start;
    logic              steal_evt;

    voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .INC_W(IW)) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .key_in       (key_in),
        .sample_tick  (sample_tick),
        .voice_active (voice_active),
        .voice_key    (voice_key),
        .voice_inc    (voice_inc),
        .voice_start  (voice_start),
        .steal_evt    (steal_evt)
    );

    // ---------------- clock ----------------
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int inc_tab[10] = '{91446, 102641, 115214, 122064, 137013,
                        153791, 172624, 182891, 205288, 230425};

    int m_key[NV];    // key held by each shadow voice, -1 when idle
    int m_age[NV];
    bit m_pend[NV];
    bit m_ack[NK];
    bit m_blk[NK];
    int c_key[NV];    // committed key per voice, -1 when idle
    bit c_start[NV];
    bit c_steal;

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_key[v] = -1; m_age[v] = 0; m_pend[v] = 0;
            c_key[v] = -1; c_start[v] = 0;
        end
        for (int k = 0; k < NK; k++) begin
            m_ack[k] = 0; m_blk[k] = 0;
        end
        c_steal = 0;
    endfunction

    function automatic void model_step(input logic [NK-1:0] keys, input logic tick);
        int rel = -1;
        int prs = -1;
        int tgt = -1;
        for (int k = 0; k < NK; k++) begin
            if (rel < 0 && !keys[k] && m_ack[k]) rel = k;
            if (prs < 0 && keys[k] && !m_ack[k] && !m_blk[k]) prs = k;
        end
        for (int k = 0; k < NK; k++) if (!keys[k]) m_blk[k] = 0;
        c_steal = 0;
        if (rel >= 0) begin
            m_ack[rel] = 0;
            for (int v = 0; v < NV; v++)
                if (m_key[v] == rel) begin
                    m_key[v] = -1;
                    m_pend[v] = 0;
                end
        end else if (prs >= 0) begin
            for (int v = 0; v < NV; v++) if (tgt < 0 && m_key[v] < 0) tgt = v;
            if (tgt < 0) begin
                int best = -1;
                for (int v = 0; v < NV; v++) if (m_age[v] > best) begin best = m_age[v]; tgt = v; end
                c_steal = 1;
                m_ack[m_key[tgt]] = 0;
                m_blk[m_key[tgt]] = 1;
            end
            for (int v = 0; v < NV; v++)
                if (v != tgt && m_key[v] >= 0) m_age[v] = (m_age[v] + 1 > NV - 1) ? NV - 1 : m_age[v] + 1;
            m_age[tgt] = 0;
            m_key[tgt] = prs;
            m_pend[tgt] = 1;
            m_ack[prs] = 1;
        end
        for (int v = 0; v < NV; v++) c_start[v] = 0;
        if (tick) begin
            for (int v = 0; v < NV; v++) begin
                c_key[v] = m_key[v];
                c_start[v] = m_pend[v];
                m_pend[v] = 0;
            end
        end
    endfunction

    function automatic logic [W-1:0] model_word();
        logic [NV-1:0]    a;
        logic [4*NV-1:0]  kk;
        logic [IW*NV-1:0] ii;
        logic [NV-1:0]    s;
        for (int v = 0; v < NV; v++) begin
            a[v] = (c_key[v] >= 0);
            kk[4*v +: 4] = (c_key[v] >= 0) ? 4'(c_key[v]) : 4'hF;
            ii[IW*v +: IW] = (c_key[v] >= 0) ? IW'(inc_tab[c_key[v]]) : '0;
            s[v] = c_start[v];
        end
        return {c_steal, s, ii, kk, a};
    endfunction

    task automatic compare_now(input string tag);
        logic [W-1:0] e;
        exp_q.push_back(model_word());
        e = exp_q.pop_front();
        check(tag, 128'({steal_evt, voice_start, voice_inc, voice_key, voice_active}), 128'(e));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [NK-1:0] keys, input logic tick, input string tag);
        key_in = keys;
        sample_tick = tick;
        @(posedge CLOCK_50);
        model_step(keys, tick);
        #1;
        compare_now(tag);
    endtask

    // Asserts reset between edges and expects outputs to clear at once.
    task automatic async_reset();
        resetn = 1'b0;
        model_reset();
        #1;
        compare_now("async_rst");
        @(posedge CLOCK_50);
        #1;
        compare_now("rst_hold");
        resetn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NK-1:0] keys;
        resetn = 1'b0;
        key_in = '0;
        sample_tick = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        compare_now("reset");
        check("rst_key", 128'(voice_key), 128'(16'hFFFF));
        check("rst_act", 128'(voice_active), 128'(0));
        resetn = 1'b1;

        // 1: single press then tick
        step(10'b00_0010_0000, 1'b0, "s1_press");
        step(10'b00_0010_0000, 1'b1, "s1_tick");
        check("s1_act", 128'(voice_active), 128'(4'b0001));
        check("s1_key", 128'(voice_key[3:0]), 128'(5));
        check("s1_inc", 128'(voice_inc[17:0]), 128'(153791));
        check("s1_start", 128'(voice_start), 128'(4'b0001));
        step('0, 1'b0, "s1_rel");
        step('0, 1'b1, "s1_clr");

        // 2: four simultaneous presses are serviced one per cycle
        for (int i = 0; i < 4; i++) step(10'b00_0000_1111, 1'b0, "s2_press");
        step(10'b00_0000_1111, 1'b1, "s2_tick");
        check("s2_key", 128'(voice_key), 128'(16'h3210));
        check("s2_start", 128'(voice_start), 128'(4'b1111));

        // 3: a fifth key steals the oldest voice
        step(10'b10_0000_1111, 1'b0, "s3_press");
        check("s3_steal", 128'(steal_evt), 128'(1));
        step(10'b10_0000_1111, 1'b0, "s3_hold");
        check("s3_nosteal", 128'(steal_evt), 128'(0));
        step(10'b10_0000_1111, 1'b1, "s3_tick");
        check("s3_key", 128'(voice_key), 128'(16'h3219));
        check("s3_start", 128'(voice_start), 128'(4'b0001));

        // 4: release key 2
        step(10'b10_0000_1011, 1'b1, "s4_tick");
        check("s4_key", 128'(voice_key), 128'(16'h3F19));
        check("s4_act", 128'(voice_active), 128'(4'b1011));
        check("s4_inc2", 128'(voice_inc[36 +: 18]), 128'(0));
        check("s4_start", 128'(voice_start), 128'(0));

        // 5: key 4 pulses inside one tick period
        step(10'b10_0001_1011, 1'b0, "s5_on");
        step(10'b10_0000_1011, 1'b0, "s5_off");
        step(10'b10_0000_1011, 1'b1, "s5_tick");
        check("s5_key", 128'(voice_key), 128'(16'h3F19));
        check("s5_start", 128'(voice_start), 128'(0));

        // 6: reset with three active voices
        key_in = '0;
        async_reset();
        check("s6_act", 128'(voice_active), 128'(0));
        check("s6_key", 128'(voice_key), 128'(16'hFFFF));
        step('0, 1'b1, "s6_tick");

        // Randomized phase.
        keys = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) keys[$urandom_range(0, NK - 1)] ^= 1'b1;
            if ($urandom_range(0, 399) == 0) async_reset();
            step(keys, 1'b1 && ($urandom_range(0, 3) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
